p2p_upper_arb: RTL
==================

// Module: p2p_upper_arb
// PURPOSE
//  Packet-atomic round-robin arbiter merging CHNL_NUM device-side P2P streams into the single
//  p2p_upper_* forward-up channel consumed by the P2P initiator. Sits directly upstream of P2P.
//  Stamps the granted channel index into head src_dev. Single registered output stage.
// PARAMETERS
//  CHNL_NUM      4               number of input channels (2..8)
//  CHNL_NUM_LOG  2               clog2(CHNL_NUM)
//  UHEAD_W       `P2P_UHEAD_W    head width (>=48)
//  DATA_W        `P2P_DATA_W     data width
//  STAMP_SRC     1               1: overwrite head[39:32] with channel index; 0: pass head unchanged
// PORTS
//  clk              in   1                 clock
//  rst_n            in   1                 async active-low reset
//  s_upper_valid    in   CHNL_NUM          per-channel beat valid
//  s_upper_last     in   CHNL_NUM          per-channel last beat
//  s_upper_head     in   CHNL_NUM*UHEAD_W  per-channel head, valid on first beat only
//  s_upper_data     in   CHNL_NUM*DATA_W   per-channel data
//  s_upper_ready    out  CHNL_NUM          per-channel ready
//  p2p_upper_valid  out  1                 merged beat valid, to P2P
//  p2p_upper_last   out  1                 merged last
//  p2p_upper_head   out  UHEAD_W           merged head (|63:48 rsvd|47:40 dst|39:32 src|31:16 rsvd|15:0 len|)
//  p2p_upper_data   out  DATA_W            merged data
//  p2p_upper_ready  in   1                 from P2P
//  stat_clr         in   1                 (P2P_UP_ARB_STAT_EN only) clear counters
//  stat_pkt_cnt     out  CHNL_NUM*32       (P2P_UP_ARB_STAT_EN only) per-channel packet count
// BEHAVIOUR
//  - Reset: p2p_upper_valid/last/head/data=0, s_upper_ready=0, state=IDLE, rr pointer=0, counters=0.
//  - out_acc = !p2p_upper_valid || p2p_upper_ready; output stage loads on out_acc and an input handshake.
//  - Latency: 1 cycle input handshake -> output beat; full throughput, no bubble between packets.
//  - FSM IDLE: if any valid && out_acc, pick = first valid channel at or after ptr (wrapping at CHNL_NUM-1 -> 0);
//    ready[pick]=1 same cycle, first beat moves; if beat also last, stay IDLE, else go LOCK(pick).
//    ptr <= pick+1 (mod CHNL_NUM) on every first-beat handshake.
//  - LOCK: ready[g]=out_acc only for granted g, all others 0; on last-beat handshake -> IDLE.
//    Grant never changes mid-packet, even if g deasserts valid for many cycles.
//  - Head: loaded into output only on first beat; held for remaining beats; STAMP_SRC=1 sets [39:32]=g (zero-ext).
//  - Single-beat packets (valid&last on first beat) fully supported back-to-back from any channels.
//  - All channels valid continuously -> grants strictly rotate 0,1,2,3,0...
//  - Output beat held stable while p2p_upper_valid && !p2p_upper_ready (AXIS rules); inputs see ready=0.
//  - Reset mid-packet: output dropped, grant cleared; sources must restart packet after reset.
//  - No length check: last alone delimits packets.
// CONFIGURATION
//  `P2P_UP_ARB_STAT_EN defined: 32-bit wrapping counter per channel, +1 on each last-beat input handshake;
//   stat_clr zeroes all (clear wins over simultaneous increment); ports present.
//  Undefined: counters, stat_clr and stat_pkt_cnt ports absent; arbitration identical.
// STRUCTURE
//  - Shared defines header: `P2P_UHEAD_W, `P2P_DATA_W, src_dev field msb/lsb (39/32), dst_dev (47/40),
//    state encodings P2P_ARB_IDLE/P2P_ARB_LOCK.
//  - Sub-module p2p_rr_pick: combinational round-robin pick (req vector, ptr -> one-hot + index, any).
//  - Top holds FSM, ptr, grant register, output stage, optional stats.
// TESTING
//  1 Reset: hold rst_n=0 with all valid=1 -> p2p_upper_valid=0, s_upper_ready=0; release -> chnl0 granted first.
//  2 All 4 channels send 3-beat packets continuously, ready=1 -> output order 0,1,2,3,0; 12 beats in 12 cycles,
//    src field = 0..3, no interleaving within packet.
//  3 Chnl2 sends beat1, drops valid 5 cycles, chnl0/1 valid -> no other channel granted until chnl2 last.
//  4 p2p_upper_ready toggles 1010 random -> every beat delivered once, in order, head/data stable while stalled.
//  5 Single-beat packets from chnl1 and chnl3 alternately, STAMP_SRC=0 -> head passed bit-exact, one pkt/cycle.
//  6 STAT_EN: chnl0 sends 5 pkts, stat_clr pulsed on 5th last-beat -> cnt0=0; then 2 pkts -> cnt0=2.

Source files
------------

// File: rtl/p2p_upper_arb_pkg.sv
// -----------------------------------------------------------------------------
// p2p_upper_arb_pkg
//   Shared definitions for the P2P forward-up arbiter:
//   - default head/data widths of the p2p_upper_* channel
//   - bit positions of the src_dev / dst_dev fields inside the head
//   - arbiter FSM state encodings
// -----------------------------------------------------------------------------
package p2p_upper_arb_pkg;

  localparam int P2P_UHEAD_W = 64;
  localparam int P2P_DATA_W  = 64;

  // Head layout: |63:48 rsvd|47:40 dst|39:32 src|31:16 rsvd|15:0 len|
  localparam int P2P_SRC_DEV_MSB = 39;
  localparam int P2P_SRC_DEV_LSB = 32;
  localparam int P2P_DST_DEV_MSB = 47;
  localparam int P2P_DST_DEV_LSB = 40;
  localparam int P2P_DEV_W       = P2P_SRC_DEV_MSB - P2P_SRC_DEV_LSB + 1;

  typedef enum logic {
    P2P_ARB_IDLE = 1'b0,  // between packets, free to pick a new channel
    P2P_ARB_LOCK = 1'b1   // mid-packet, grant frozen on one channel
  } p2p_arb_state_e;

endpackage

// File: rtl/p2p_rr_pick.sv
// -----------------------------------------------------------------------------
// p2p_rr_pick
//   Combinational round-robin pick: first requesting channel at or after ptr,
//   wrapping from N-1 back to 0.
// Ports:
//   req      in   N      request vector
//   ptr      in   IDX_W  highest-priority channel index
//   gnt_oh   out  N      one-hot pick (all zero when nothing requests)
//   gnt_idx  out  IDX_W  binary index of the pick (0 when nothing requests)
//   any      out  1      at least one request present
// -----------------------------------------------------------------------------
module p2p_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise the unassigned paths infer latches.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int off = 0; off < N; off++) begin
      idx = IDX_W'((int'(ptr) + off) % N);
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt_oh[idx]  = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/p2p_upper_arb.sv
// -----------------------------------------------------------------------------
// p2p_upper_arb
//   Packet-atomic round-robin arbiter merging CHNL_NUM device-side streams into
//   the single p2p_upper_* channel feeding the P2P initiator. Once a channel's
//   first beat is accepted the grant is held until its last beat, regardless of
//   gaps in that channel's valid. Optionally stamps the granted index into the
//   head src_dev field. One registered output stage, full throughput.
// Optional feature:
//   P2P_UP_ARB_STAT_EN  per-channel 32-bit packet counters (stat_clr /
//                       stat_pkt_cnt ports exist only when defined)
// Ports:
//   clk, rst_n        clock, async active-low reset
//   s_upper_valid     in   CHNL_NUM          per-channel beat valid
//   s_upper_last      in   CHNL_NUM          per-channel last beat
//   s_upper_head      in   CHNL_NUM*UHEAD_W  per-channel head (first beat only)
//   s_upper_data      in   CHNL_NUM*DATA_W   per-channel data
//   s_upper_ready     out  CHNL_NUM          per-channel ready
//   p2p_upper_valid   out  1                 merged beat valid
//   p2p_upper_last    out  1                 merged last
//   p2p_upper_head    out  UHEAD_W           merged head
//   p2p_upper_data    out  DATA_W            merged data
//   p2p_upper_ready   in   1                 backpressure from P2P
//   stat_clr          in   1                 clear all packet counters
//   stat_pkt_cnt      out  CHNL_NUM*32       per-channel packet counts
// -----------------------------------------------------------------------------
module p2p_upper_arb
  import p2p_upper_arb_pkg::*;
#(
  parameter int CHNL_NUM     = 4,
  parameter int CHNL_NUM_LOG = 2,
  parameter int UHEAD_W      = P2P_UHEAD_W,
  parameter int DATA_W       = P2P_DATA_W,
  parameter int STAMP_SRC    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHNL_NUM-1:0]          s_upper_valid,
  input  logic [CHNL_NUM-1:0]          s_upper_last,
  input  logic [CHNL_NUM*UHEAD_W-1:0]  s_upper_head,
  input  logic [CHNL_NUM*DATA_W-1:0]   s_upper_data,
  output logic [CHNL_NUM-1:0]          s_upper_ready,
  output logic                         p2p_upper_valid,
  output logic                         p2p_upper_last,
  output logic [UHEAD_W-1:0]           p2p_upper_head,
  output logic [DATA_W-1:0]            p2p_upper_data,
  input  logic                         p2p_upper_ready
`ifdef P2P_UP_ARB_STAT_EN
  ,
  input  logic                         stat_clr,
  output logic [CHNL_NUM*32-1:0]       stat_pkt_cnt
`endif
);

  p2p_arb_state_e          state_q, state_d;
  logic [CHNL_NUM_LOG-1:0] ptr_q;
  logic [CHNL_NUM_LOG-1:0] grant_q;
  logic [CHNL_NUM_LOG-1:0] sel;
  logic                    run_q;

  logic [CHNL_NUM-1:0]     pick_oh;
  logic [CHNL_NUM_LOG-1:0] pick_idx;
  logic                    pick_any;

  logic                    out_acc;
  logic [CHNL_NUM-1:0]     hs_vec;
  logic                    in_hs;
  logic                    sel_last;
  logic                    first_beat;
  logic [UHEAD_W-1:0]      head_in;
  logic [DATA_W-1:0]       data_in;

  // Output register can take a beat when empty or draining this cycle.
  assign out_acc    = !p2p_upper_valid || p2p_upper_ready;
  assign first_beat = (state_q == P2P_ARB_IDLE);

  p2p_rr_pick #(
    .N     (CHNL_NUM),
    .IDX_W (CHNL_NUM_LOG)
  ) u_pick (
    .req     (s_upper_valid),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Ready generation. run_q keeps all readies low while reset is held and for
  // the first edge after release, so no beat is taken into a resetting stage.
  always_comb begin
    s_upper_ready = '0;
    sel           = grant_q;
    case (state_q)
      P2P_ARB_IDLE: begin
        sel = pick_idx;
        if (run_q && pick_any && out_acc) s_upper_ready = pick_oh;
      end
      P2P_ARB_LOCK: begin
        // Frozen on the granted channel even while it has no valid.
        s_upper_ready[grant_q] = out_acc;
      end
    endcase
  end

  assign hs_vec   = s_upper_valid & s_upper_ready;
  assign in_hs    = |hs_vec;
  assign sel_last = s_upper_last[sel];
  assign data_in  = s_upper_data[int'(sel)*DATA_W +: DATA_W];

  always_comb begin
    head_in = s_upper_head[int'(sel)*UHEAD_W +: UHEAD_W];
    if (STAMP_SRC != 0)
      head_in[P2P_SRC_DEV_MSB:P2P_SRC_DEV_LSB] = P2P_DEV_W'(sel);
  end

  always_comb begin
    state_d = state_q;
    if (in_hs) begin
      case (state_q)
        P2P_ARB_IDLE: if (!sel_last) state_d = P2P_ARB_LOCK;
        P2P_ARB_LOCK: if (sel_last)  state_d = P2P_ARB_IDLE;
      endcase
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= P2P_ARB_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      if (in_hs && first_beat) begin
        grant_q <= pick_idx;
        ptr_q   <= (pick_idx == CHNL_NUM_LOG'(CHNL_NUM - 1)) ? '0
                                                             : pick_idx + 1'b1;
      end
    end
  end

  // Output stage: head captured on the first beat only and held for the rest
  // of the packet; whole beat held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2p_upper_valid <= 1'b0;
      p2p_upper_last  <= 1'b0;
      p2p_upper_head  <= '0;
      p2p_upper_data  <= '0;
    end else if (in_hs) begin
      p2p_upper_valid <= 1'b1;
      p2p_upper_last  <= sel_last;
      p2p_upper_data  <= data_in;
      if (first_beat) p2p_upper_head <= head_in;
    end else if (p2p_upper_ready) begin
      p2p_upper_valid <= 1'b0;
    end
  end

`ifdef P2P_UP_ARB_STAT_EN
  logic [31:0] cnt_q [CHNL_NUM];

  // NOTE: the counter array is a bank of flops (not a RAM), so it is cleared
  // by reset like any other state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHNL_NUM; i++) cnt_q[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < CHNL_NUM; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < CHNL_NUM; i++)
        if (hs_vec[i] && s_upper_last[i]) cnt_q[i] <= cnt_q[i] + 32'd1;
    end
  end

  for (genvar g = 0; g < CHNL_NUM; g++) begin : g_stat
    assign stat_pkt_cnt[g*32 +: 32] = cnt_q[g];
  end
`else
  // Statistics disabled: arbitration is unaffected.
`endif

endmodule
